// File: rtl/disk_shift_sequencer.sv
// disk_shift_sequencer
//
// Drives the control pins of an external LS194-style universal shift register
// so that it serves as the Disk II byte serializer/deserializer.
//
//   write (mode = 1): bytes are accepted on a valid/ready handshake, loaded in
//                     parallel, then shifted out MSB-first, one bit per tick.
//   read  (mode = 0): the serial stream is shifted in, one bit per tick, and
//                     each completed byte is presented on rd_data together
//                     with a one-cycle rd_valid pulse.
//
// Ports
//   Clk, Reset           system clock, synchronous active-high reset
//   mode                 1 = write, 0 = read (sampled only in IDLE)
//   bit_tick             one-cycle strobe per bit cell
//   rd_bit               serial read data, sampled on bit_tick
//   wr_data/wr_valid     byte to write and its valid flag
//   wr_ready             byte accepted when wr_valid & wr_ready
//   wr_bit               serial write data (register MSB while shifting out)
//   rd_data/rd_valid     last completed read byte and its update pulse
//   sr_s1, sr_s0         shift register mode select (11 load, 01 shift, 00 hold)
//   sr_clear_n           active-low clear to the shift register
//   sr_srsi, sr_slsi     serial inputs at bit 0 / MSB (slsi unused, tied 0)
//   sr_p                 parallel load value (wr_data)
//   sr_q                 shift register contents
//
// The register pins are combinational so that the shift register acts on the
// same clock edge on which this controller changes state.

module disk_shift_sequencer #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  mode,
    input  logic                  bit_tick,
    input  logic                  rd_bit,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic                  wr_bit,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  sr_s1,
    output logic                  sr_s0,
    output logic                  sr_clear_n,
    output logic                  sr_srsi,
    output logic                  sr_slsi,
    output logic [DATA_WIDTH-1:0] sr_p,
    input  logic [DATA_WIDTH-1:0] sr_q
);

    localparam int unsigned CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SHIFT_OUT = 2'd1,
        SHIFT_IN  = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] bitcnt;
    logic             rst_hold;   // high on the first cycle after Reset drops
    logic             quiet;      // reset or its trailing cycle: controls inert
    logic             last_bit;

    assign quiet    = Reset | rst_hold;
    assign last_bit = (bitcnt == LAST_BIT);

    // Right shifts are never used and the parallel input always mirrors wr_data.
    assign sr_slsi = 1'b0;
    assign sr_p    = wr_data;

    // Shift register controls, handshake ready and serial write bit.
    always_comb begin
        wr_ready   = 1'b0;
        wr_bit     = 1'b0;
        sr_s1      = 1'b0;
        sr_s0      = 1'b0;
        sr_srsi    = 1'b0;
        sr_clear_n = 1'b1;

        if (quiet) begin
            // Hold the register cleared and frozen around reset.
            sr_clear_n = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mode) begin
                        wr_ready = 1'b1;
                        if (wr_valid) begin
                            sr_s1 = 1'b1;
                            sr_s0 = 1'b1;
                        end
                    end else begin
                        sr_clear_n = 1'b0;
                    end
                end

                SHIFT_OUT: begin
                    wr_bit = sr_q[DATA_WIDTH-1];
                    if (bit_tick) begin
                        if (last_bit) begin
                            // Final bit cell: a waiting byte is reloaded with no gap.
                            wr_ready = 1'b1;
                            sr_s1    = wr_valid;
                            sr_s0    = 1'b1;
                        end else begin
                            sr_s0 = 1'b1;
                        end
                    end
                end

                SHIFT_IN: begin
                    if (bit_tick) begin
                        sr_s0   = 1'b1;
                        sr_srsi = rd_bit;
                    end
                end

                default: begin
                    sr_clear_n = 1'b0;
                end
            endcase
        end
    end

    // Sequencer state, bit counter and read byte capture.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            bitcnt   <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            rst_hold <= 1'b1;
        end else begin
            rst_hold <= 1'b0;
            rd_valid <= 1'b0;

            if (!rst_hold) begin
                case (state)
                    IDLE: begin
                        // Any bit_tick here is ignored; counting starts on the next one.
                        if (mode) begin
                            if (wr_valid) begin
                                bitcnt <= '0;
                                state  <= SHIFT_OUT;
                            end
                        end else begin
                            bitcnt <= '0;
                            state  <= SHIFT_IN;
                        end
                    end

                    SHIFT_OUT: begin
                        // mode is ignored so a byte is never truncated.
                        if (bit_tick) begin
                            if (last_bit) begin
                                bitcnt <= '0;
                                if (!wr_valid) begin
                                    state <= IDLE;
                                end
                            end else begin
                                bitcnt <= bitcnt + CNT_W'(1);
                            end
                        end
                    end

                    SHIFT_IN: begin
                        if (bit_tick) begin
                            if (last_bit) begin
                                // The register shifts on this same edge, so the
                                // finished byte is assembled from sr_q and rd_bit.
                                rd_data  <= {sr_q[DATA_WIDTH-2:0], rd_bit};
                                rd_valid <= 1'b1;
                                bitcnt   <= '0;
                            end else begin
                                bitcnt <= bitcnt + CNT_W'(1);
                            end
                        end else if (mode) begin
                            // Abort: the partial byte is discarded.
                            bitcnt <= '0;
                            state  <= IDLE;
                        end
                    end

                    default: begin
                        bitcnt <= '0;
                        state  <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_disk_shift_sequencer.sv
// Self-checking bench for disk_shift_sequencer with a behavioural LS194 model.
module tb_disk_shift_sequencer;

    localparam int unsigned W = 8;

    logic         Clk;
    logic         Reset;
    logic         mode;
    logic         bit_tick;
    logic         rd_bit;
    logic [W-1:0] wr_data;
    logic         wr_valid;
    logic         wr_ready;
    logic         wr_bit;
    logic [W-1:0] rd_data;
    logic         rd_valid;
    logic         sr_s1;
    logic         sr_s0;
    logic         sr_clear_n;
    logic         sr_srsi;
    logic         sr_slsi;
    logic [W-1:0] sr_p;
    logic [W-1:0] sr_q;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] wq[$];       // bytes for the next write stream
    logic         rq[$];       // bits for the next read stream
    logic [W-1:0] last_rd;     // expected rd_data

    disk_shift_sequencer #(.DATA_WIDTH(W)) dut (
        .Clk(Clk), .Reset(Reset), .mode(mode), .bit_tick(bit_tick),
        .rd_bit(rd_bit), .wr_data(wr_data), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .wr_bit(wr_bit), .rd_data(rd_data),
        .rd_valid(rd_valid), .sr_s1(sr_s1), .sr_s0(sr_s0),
        .sr_clear_n(sr_clear_n), .sr_srsi(sr_srsi), .sr_slsi(sr_slsi),
        .sr_p(sr_p), .sr_q(sr_q)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Universal shift register behaviour (clear dominates, then mode select).
    always_ff @(posedge Clk) begin
        if (!sr_clear_n) begin
            sr_q <= '0;
        end else begin
            case ({sr_s1, sr_s0})
                2'b11:   sr_q <= sr_p;
                2'b01:   sr_q <= {sr_q[W-2:0], sr_srsi};
                2'b10:   sr_q <= {sr_slsi, sr_q[W-1:1]};
                default: sr_q <= sr_q;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change just after the rising edge; outputs are sampled mid-cycle.
    task automatic next_cycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_wr_ready"}, 32'(wr_ready), 32'(0));
        chk({tag, "_wr_bit"}, 32'(wr_bit), 32'(0));
        chk({tag, "_rd_valid"}, 32'(rd_valid), 32'(0));
        chk({tag, "_ctl"}, 32'({sr_s1, sr_s0}), 32'(0));
        chk({tag, "_clear_n"}, 32'(sr_clear_n), 32'(0));
    endtask

    // Writes every byte in wq back to back; gap < 0 picks random tick spacing.
    task automatic write_stream(input int gap);
        int n;
        logic [W-1:0] b;
        n = wq.size();
        mode     = 1'b1;
        bit_tick = 1'b0;
        wr_data  = wq[0];
        wr_valid = 1'b1;
        settle();
        chk("wr_ready_idle", 32'(wr_ready), 32'(1));
        next_cycle();
        for (int j = 0; j < n; j++) begin
            b        = wq[j];
            wr_valid = (j + 1 < n);
            if (j + 1 < n) wr_data = wq[j+1];
            for (int i = 0; i < int'(W); i++) begin
                int g;
                g = (gap < 0) ? int'($urandom_range(3, 0)) : gap;
                for (int k = 0; k < g; k++) begin
                    bit_tick = 1'b0;
                    settle();
                    chk("wr_bit_hold", 32'(wr_bit), 32'(b[W-1-i]));
                    chk("wr_ready_busy", 32'(wr_ready), 32'(0));
                    next_cycle();
                end
                bit_tick = 1'b1;
                settle();
                chk("wr_bit_tick", 32'(wr_bit), 32'(b[W-1-i]));
                chk("wr_ready_tick", 32'(wr_ready), 32'(i == int'(W) - 1));
                next_cycle();
            end
        end
        bit_tick = 1'b0;
        wr_valid = 1'b0;
        settle();
        chk("wr_end_ready", 32'(wr_ready), 32'(1));
        chk("wr_end_bit", 32'(wr_bit), 32'(0));
        chk("wr_end_sr_q", 32'(sr_q), 32'(0));
        next_cycle();
    endtask

    task automatic chk_rd(input logic pending);
        chk("rd_valid", 32'(rd_valid), 32'(pending));
        chk("rd_data", 32'(rd_data), 32'(last_rd));
        chk("rd_clear_n", 32'(sr_clear_n), 32'(1));
    endtask

    // Reads every bit in rq, then leaves via mode = 1. With tick_abort the
    // mode change coincides with the final tick, which must still count.
    task automatic read_stream(input logic tick_abort);
        logic [W-1:0] acc;
        int nb;
        logic pending;
        acc     = '0;
        nb      = 0;
        pending = 1'b0;
        mode     = 1'b0;
        bit_tick = 1'b1;
        rd_bit   = 1'($urandom);
        settle();
        chk("rd_start_clear_n", 32'(sr_clear_n), 32'(0));
        chk("rd_start_ctl", 32'({sr_s1, sr_s0}), 32'(0));
        next_cycle();
        for (int k = 0; k < rq.size(); k++) begin
            int g;
            g = int'($urandom_range(3, 0));
            for (int c = 0; c < g; c++) begin
                bit_tick = 1'b0;
                settle();
                chk_rd(pending);
                next_cycle();
                pending = 1'b0;
            end
            bit_tick = 1'b1;
            rd_bit   = rq[k];
            if (tick_abort && k == rq.size() - 1) mode = 1'b1;
            settle();
            chk_rd(pending);
            chk("rd_ctl", 32'({sr_s1, sr_s0}), 32'(1));
            chk("rd_srsi", 32'(sr_srsi), 32'(rq[k]));
            next_cycle();
            pending = 1'b0;
            acc = {acc[W-2:0], rq[k]};
            nb++;
            if (nb == int'(W)) begin
                nb      = 0;
                last_rd = acc;
                pending = 1'b1;
            end
        end
        bit_tick = 1'b0;
        mode     = 1'b1;
        settle();
        chk_rd(pending);
        chk("rd_abort_ready", 32'(wr_ready), 32'(0));
        next_cycle();
        settle();
        chk("rd_idle_valid", 32'(rd_valid), 32'(0));
        chk("rd_idle_data", 32'(rd_data), 32'(last_rd));
        chk("rd_idle_ready", 32'(wr_ready), 32'(1));
        next_cycle();
    endtask

    initial begin
        logic [15:0] pat;
        logic [W-1:0] b;

        Reset    = 1'b1;
        mode     = 1'b1;
        bit_tick = 1'b0;
        rd_bit   = 1'b0;
        wr_data  = '0;
        wr_valid = 1'b0;
        last_rd  = '0;

        // Reset held for three cycles.
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            settle();
            chk_reset_outputs("reset");
            chk("reset_rd_data", 32'(rd_data), 32'(0));
        end
        next_cycle();
        Reset = 1'b0;
        settle();
        chk_reset_outputs("post_reset");
        next_cycle();
        settle();
        chk("released_ready", 32'(wr_ready), 32'(1));
        next_cycle();

        // 0xA5 with a tick every fourth cycle.
        wq = {};
        wq.push_back(8'hA5);
        write_stream(3);

        // 0xFF then 0x00 reloaded gaplessly.
        wq = {};
        wq.push_back(8'hFF);
        wq.push_back(8'h00);
        write_stream(-1);

        // Random writes.
        for (int t = 0; t < 3; t++) begin
            wq = {};
            for (int j = 0; j <= int'($urandom_range(2, 0)); j++) wq.push_back(W'($urandom));
            write_stream(-1);
        end

        // Directed read: 0xD5 then 0x96.
        pat = 16'hD596;
        rq = {};
        for (int i = 15; i >= 0; i--) rq.push_back(pat[i]);
        read_stream(1'b0);
        chk("read_directed", 32'(last_rd), 32'(8'h96));

        // Random reads, including partial trailing bytes.
        for (int t = 0; t < 2; t++) begin
            rq = {};
            for (int i = 0; i < int'($urandom_range(24, 8)); i++) rq.push_back(1'($urandom));
            read_stream(1'b0);
        end

        // Five bits then abort; mode rises on the fifth tick.
        rq = {};
        for (int i = 0; i < 5; i++) rq.push_back(1'($urandom));
        read_stream(1'b1);

        // A following read still clears the register first and works.
        rq = {};
        for (int i = 0; i < int'(W); i++) rq.push_back(1'($urandom));
        read_stream(1'b0);

        // Reset after the fourth bit of a write.
        b        = 8'h5A;
        mode     = 1'b1;
        wr_data  = b;
        wr_valid = 1'b1;
        next_cycle();
        wr_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bit_tick = 1'b0;
            settle();
            chk("pre_reset_bit", 32'(wr_bit), 32'(b[W-1-i]));
            next_cycle();
            bit_tick = 1'b1;
            next_cycle();
        end
        bit_tick = 1'b0;
        Reset    = 1'b1;
        settle();
        chk_reset_outputs("mid_reset");
        next_cycle();
        settle();
        chk_reset_outputs("mid_reset_held");
        chk("mid_reset_sr_q", 32'(sr_q), 32'(0));
        next_cycle();
        Reset = 1'b0;
        settle();
        chk_reset_outputs("mid_post_reset");
        chk("mid_post_rd_valid", 32'(rd_valid), 32'(0));
        next_cycle();

        wq = {};
        wq.push_back(8'h3C);
        write_stream(-1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/disk_shift_sequencer.md
# disk_shift_sequencer

Controller that sequences an external `shift_reg_ls194`-style universal shift register, configured `DATA_WIDTH` wide, as the Disk II byte serializer/deserializer. In write mode it parallel-loads bytes offered on a valid/ready handshake and shifts them out MSB-first, one bit per `bit_tick`. In read mode it shifts the incoming bit stream in and presents each completed byte on `rd_data` with a one-cycle `rd_valid`. It sits between the disk controller's byte-level logic and the shift register instance, and is the only driver of that register's control pins.

## Interface
- `DATA_WIDTH`, 8, byte width; must match the shift register instance; ≥2.
- `Clk`  in  1  system clock; all state changes on rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `mode`  in  1  1 = write (serialize), 0 = read (deserialize); sampled only in IDLE.
- `bit_tick`  in  1  one-cycle strobe per bit cell; at most one per cycle.
- `rd_bit`  in  1  serial read data; sampled on `bit_tick` cycles.
- `wr_data`  in  DATA_WIDTH  byte to write.
- `wr_valid`  in  1  `wr_data` is valid.
- `wr_ready`  out  1  byte accepted when `wr_valid & wr_ready`.
- `wr_bit`  out  1  serial write data = `sr_q[DATA_WIDTH-1]` in SHIFT_OUT, else 0.
- `rd_data`  out  DATA_WIDTH  last completed read byte (registered).
- `rd_valid`  out  1  one-cycle pulse: `rd_data` updated.
- `sr_s1`, `sr_s0`  out  1 each  shift register mode select (11 load, 01 shift toward MSB, 00 hold).
- `sr_clear_n`  out  1  active-low clear to the shift register.
- `sr_srsi`  out  1  serial input into bit 0.
- `sr_slsi`  out  1  tied 0 (right shift unused).
- `sr_p`  out  DATA_WIDTH  parallel load value (= `wr_data`).
- `sr_q`  in  DATA_WIDTH  shift register contents.

## Operation
- States: IDLE, SHIFT_OUT, SHIFT_IN. 3-bit counter `bitcnt` (width `$clog2(DATA_WIDTH)`) counts bits completed in the current byte.
- Register controls are combinational from the current state and inputs. The shift register acts on the same edge that the controller transitions on.
- Default controls: `sr_s1:sr_s0`=00, `sr_srsi`=0, `sr_clear_n`=1.
- IDLE, `mode`=1:
  - `wr_ready`=1.
  - On handshake, drive 11 (load `wr_data`), clear `bitcnt`, go to SHIFT_OUT.
- IDLE, `mode`=0:
  - Drive `sr_clear_n`=0, clear `bitcnt`, go to SHIFT_IN.
- SHIFT_OUT:
  - `wr_ready`=0 except on the last-bit tick.
  - On `bit_tick` with `bitcnt`<DATA_WIDTH-1: drive 01, `sr_srsi`=0, increment `bitcnt`.
  - On `bit_tick` with `bitcnt`=DATA_WIDTH-1 (last bit), `wr_ready`=1:
    - If `wr_valid`: drive 11 (gapless reload), `bitcnt`←0, stay in SHIFT_OUT.
    - Otherwise: drive 01, go to IDLE.
  - `mode` is ignored in this state; a byte is never truncated.
- SHIFT_IN:
  - On `bit_tick`: drive 01, `sr_srsi`=`rd_bit`, increment `bitcnt`.
  - On `bit_tick` with `bitcnt`=DATA_WIDTH-1: register `rd_data`←{`sr_q[DATA_WIDTH-2:0]`, `rd_bit`}, set `rd_valid`=1 for the next cycle, `bitcnt`←0. The register keeps shifting with no gap.
  - `mode`=1 with no `bit_tick`: abort. Go to IDLE and discard the partial byte (no `rd_valid`).
  - `mode`=1 together with `bit_tick`: the tick is processed first and the abort follows on the next non-tick cycle.
- `rd_data` holds its value until the next completed byte.

## Timing
- Reset (while asserted and on the first cycle after):
  - State: IDLE, `bitcnt`=0.
  - Outputs: `rd_data`=0, `rd_valid`=0, `wr_ready`=0, `wr_bit`=0.
  - Register controls: `sr_s1:sr_s0`=00, `sr_clear_n`=0.
- Reset asserted mid-byte: the byte is dropped, with no `rd_valid` and no further shifts.
- Write latency: handshake at edge N → `wr_bit` shows the MSB from cycle N+1. Each `bit_tick` advances `wr_bit` by one bit on the following cycle.
- Read latency: `rd_valid` is high the cycle after the DATA_WIDTH-th `bit_tick`.
- `bit_tick` in the same cycle as an IDLE transition is ignored; the first counted bit is the next tick.
- `bitcnt` wraps only through an explicit clear; it never reaches DATA_WIDTH.

## Test plan
- Reset with `mode`=1, `wr_valid`=0 for 3 cycles → all outputs at reset values, `sr_clear_n`=0. After release, `wr_ready`=1.
- Write 0xA5, ticks every 4 cycles → `wr_bit` sequence 1,0,1,0,0,1,0,1. After the 8th tick: IDLE, `wr_ready`=1, `sr_q`=0.
- Write 0xFF, then 0x00 offered with `wr_valid` held → the load happens on the 8th tick of 0xFF. Stream is 8 ones then 8 zeros with no gap, and `wr_ready` is high only on the reload cycles.
- Read `mode`=0, `rd_bit` stream 1,1,0,1,0,1,0,1,1,0,0,1,0,1,1,0 → `rd_valid` pulses twice, with `rd_data`=0xD5 then 0x96. Each pulse is exactly one cycle, one cycle after the 8th tick.
- Read 5 bits, then `mode`=1 → return to IDLE, no `rd_valid`, `rd_data` keeps its previous value. Next `mode`=0 pulses `sr_clear_n` low for one cycle.
- `Reset` asserted after the 4th bit of a write → IDLE, 00 controls, `sr_clear_n`=0. After release, a new write of 0x3C shifts out 0,0,1,1,1,1,0,0.
